sprattr_dbuf: RTL and testbench

Parametrised, double-buffered sprite attribute table for the video engine. The CPU reads and writes a back buffer over the same register window as the single-buffered table. On a commit request (normally start of vblank), a copy FSM transfers the whole back buffer into the front buffer, one entry per clock. The sprite line engine reads only the front buffer, through a registered port, so partially updated sprite lists never reach the screen mid-frame.

---
 rtl/sprattr_dbuf.sv | 139 +++++++++++++
 tb/tb_sprattr_dbuf.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/sprattr_dbuf.sv
// Double-buffered sprite attribute table: the CPU edits a back buffer and a commit copies it,
// one entry per clock, into the front buffer that the sprite line engine reads.
module sprattr_dbuf #(
    parameter int unsigned NUM_SPR = 64,
    parameter int unsigned Y_W     = 8,
    localparam int unsigned ADDR_W = $clog2(NUM_SPR)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W:0]   sprattr_addr,
    output logic [31:0]       sprattr_rddata,
    input  logic [31:0]       sprattr_wrdata,
    input  logic              sprattr_wren,
    input  logic              commit_req,
    output logic              commit_busy,
    output logic              commit_done,
    input  logic [ADDR_W-1:0] spr_sel,
    output logic [8:0]        spr_x,
    output logic [Y_W-1:0]    spr_y,
    output logic [9:0]        spr_idx,
    output logic              spr_priority,
    output logic [1:0]        spr_palette,
    output logic              spr_h16,
    output logic              spr_vflip,
    output logic              spr_hflip
);

    // Entry packing: {y, x, attribute[15:0]}
    localparam int unsigned ENT_W = 25 + Y_W;
    localparam logic [0:0] STATE_IDLE = 1'b0;
    localparam logic [0:0] STATE_COPY = 1'b1;
    localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(NUM_SPR - 1);

    logic [ENT_W-1:0] back_mem  [NUM_SPR];
    logic [ENT_W-1:0] front_mem [NUM_SPR];

    logic [0:0]        state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic              pending_q, pending_d;
    logic              done_q, done_d;
    logic [ENT_W-1:0]  vid_q;

    logic [ADDR_W-1:0] cpu_idx;
    logic              cpu_pos;
    logic [ENT_W-1:0]  cpu_entry;
    logic [ENT_W-1:0]  wr_entry;
    logic [ENT_W-1:0]  copy_entry;
    logic              unused_wrdata;

    assign cpu_idx   = sprattr_addr[ADDR_W-1:0];
    assign cpu_pos   = sprattr_addr[ADDR_W];
    assign cpu_entry = back_mem[cpu_idx];
    assign unused_wrdata = ^sprattr_wrdata[31:16+Y_W];

    always_comb begin
        wr_entry       = cpu_entry;
        sprattr_rddata = '0;
        if (cpu_pos) begin
            wr_entry[24:16]               = sprattr_wrdata[8:0];
            wr_entry[ENT_W-1:25]          = sprattr_wrdata[16+Y_W-1:16];
            sprattr_rddata[8:0]           = cpu_entry[24:16];
            sprattr_rddata[16+Y_W-1:16]   = cpu_entry[ENT_W-1:25];
        end else begin
            wr_entry[15:0]       = sprattr_wrdata[15:0];
            sprattr_rddata[15:0] = cpu_entry[15:0];
        end
    end

    always_ff @(posedge clk) begin
        if (sprattr_wren) begin
            back_mem[cpu_idx] <= wr_entry;
        end
    end

    // Forward a same-cycle CPU write so an entry written exactly at ptr still makes this pass.
    assign copy_entry = (sprattr_wren && cpu_idx == ptr_q) ? wr_entry : back_mem[ptr_q];

    always_ff @(posedge clk) begin
        if (state_q == STATE_COPY) begin
            front_mem[ptr_q] <= copy_entry;
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        pending_d = pending_q;
        done_d    = 1'b0;
        case (state_q)
            STATE_IDLE: begin
                if (commit_req && pending_q) begin
                    state_d   = STATE_COPY;
                    ptr_d     = '0;
                    pending_d = 1'b0;
                end
            end
            STATE_COPY: begin
                ptr_d = ptr_q + 1'b1;
                if (ptr_q == LAST_PTR) begin
                    state_d = STATE_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = STATE_IDLE;
        endcase
        // A CPU write always wins over the clear on commit entry.
        if (sprattr_wren) begin
            pending_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= STATE_IDLE;
            ptr_q     <= '0;
            pending_q <= 1'b0;
            done_q    <= 1'b0;
            vid_q     <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            pending_q <= pending_d;
            done_q    <= done_d;
            vid_q     <= front_mem[spr_sel];
        end
    end

    assign commit_busy  = (state_q == STATE_COPY);
    assign commit_done  = done_q;
    assign spr_x        = vid_q[24:16];
    assign spr_y        = vid_q[ENT_W-1:25];
    assign spr_idx      = vid_q[9:0];
    assign spr_h16      = vid_q[10];
    assign spr_hflip    = vid_q[11];
    assign spr_vflip    = vid_q[12];
    assign spr_palette  = vid_q[14:13];
    assign spr_priority = vid_q[15];

endmodule

// File: tb/tb_sprattr_dbuf.sv
// Directed bench for sprattr_dbuf: a 64-entry/Y_W=8 instance and a 128-entry/Y_W=9 instance.
module tb_sprattr_dbuf;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    logic [6:0]  addr = '0;
    logic [31:0] rddata;
    logic [31:0] wrdata = '0;
    logic        wren = 1'b0;
    logic        commit_req = 1'b0;
    logic        busy, done;
    logic [5:0]  spr_sel = '0;
    logic [8:0]  spr_x;
    logic [7:0]  spr_y;
    logic [9:0]  spr_idx;
    logic        spr_priority, spr_h16, spr_vflip, spr_hflip;
    logic [1:0]  spr_palette;

    logic [7:0]  b_addr = '0;
    logic [31:0] b_rddata;
    logic [31:0] b_wrdata = '0;
    logic        b_wren = 1'b0;
    logic        b_commit_req = 1'b0;
    logic        b_busy, b_done;
    logic [6:0]  b_spr_sel = '0;
    logic [8:0]  b_spr_x;
    logic [8:0]  b_spr_y;
    logic [9:0]  b_spr_idx;
    logic        b_spr_priority, b_spr_h16, b_spr_vflip, b_spr_hflip;
    logic [1:0]  b_spr_palette;

    sprattr_dbuf #(.NUM_SPR(64), .Y_W(8)) u_dut (
        .clk(clk), .reset_n(reset_n),
        .sprattr_addr(addr), .sprattr_rddata(rddata), .sprattr_wrdata(wrdata),
        .sprattr_wren(wren), .commit_req(commit_req), .commit_busy(busy), .commit_done(done),
        .spr_sel(spr_sel), .spr_x(spr_x), .spr_y(spr_y), .spr_idx(spr_idx),
        .spr_priority(spr_priority), .spr_palette(spr_palette), .spr_h16(spr_h16),
        .spr_vflip(spr_vflip), .spr_hflip(spr_hflip)
    );

    sprattr_dbuf #(.NUM_SPR(128), .Y_W(9)) u_big (
        .clk(clk), .reset_n(reset_n),
        .sprattr_addr(b_addr), .sprattr_rddata(b_rddata), .sprattr_wrdata(b_wrdata),
        .sprattr_wren(b_wren), .commit_req(b_commit_req), .commit_busy(b_busy),
        .commit_done(b_done),
        .spr_sel(b_spr_sel), .spr_x(b_spr_x), .spr_y(b_spr_y), .spr_idx(b_spr_idx),
        .spr_priority(b_spr_priority), .spr_palette(b_spr_palette), .spr_h16(b_spr_h16),
        .spr_vflip(b_spr_vflip), .spr_hflip(b_spr_hflip)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input bit big, input bit pos, input logic [6:0] idx, input logic [31:0] d);
        if (big) begin
            b_addr = {pos, idx}; b_wrdata = d; b_wren = 1'b1;
        end else begin
            addr = {pos, idx[5:0]}; wrdata = d; wren = 1'b1;
        end
        tick();
        wren = 1'b0;
        b_wren = 1'b0;
    endtask

    task automatic look(input logic [5:0] sel);
        spr_sel = sel;
        tick();
    endtask

    // Pulse commit_req, then count busy cycles and done pulses over a bounded window.
    task automatic run_commit(input bit big, output int busy_cyc, output int done_cnt);
        int budget;
        budget = big ? 150 : 80;
        if (big) b_commit_req = 1'b1; else commit_req = 1'b1;
        tick();
        commit_req = 1'b0;
        b_commit_req = 1'b0;
        busy_cyc = 0;
        done_cnt = 0;
        for (int i = 0; i < budget; i++) begin
            if (big ? b_busy : busy) busy_cyc++;
            if (big ? b_done : done) done_cnt++;
            tick();
        end
    endtask

    int bc, dc;

    initial begin
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_x", 32'(spr_x), 32'd0);
        check("rst_idx", 32'(spr_idx), 32'd0);
        #20 reset_n = 1'b1;
        tick();

        // Establish known front contents for entry 5.
        wr(0, 1, 7'd5, 32'h0011_0022);
        wr(0, 0, 7'd5, 32'h0000_1234);
        run_commit(0, bc, dc);
        check("first_busy", bc, 64);
        check("first_done", dc, 1);
        look(6'd5);
        check("first_x", 32'(spr_x), 32'h022);
        check("first_idx", 32'(spr_idx), 32'h234);

        // Read-back, upper bits masked, read-during-write returns old data.
        wr(0, 1, 7'd5, 32'hFE42_F123);
        addr = {1'b0, 6'd5}; wrdata = 32'hABCD_F7FF; wren = 1'b1;
        #1;
        check("rd_old", rddata, 32'h0000_1234);
        tick();
        wren = 1'b0;
        check("rd_attr", rddata, 32'h0000_F7FF);
        addr = {1'b1, 6'd5};
        #1;
        check("rd_pos", rddata, 32'h0042_0123);
        look(6'd5);
        check("front_old_x", 32'(spr_x), 32'h022);
        check("front_old_y", 32'(spr_y), 32'h11);

        run_commit(0, bc, dc);
        check("commit_busy", bc, 64);
        check("commit_done", dc, 1);
        look(6'd5);
        check("x", 32'(spr_x), 32'h123);
        check("y", 32'(spr_y), 32'h42);
        check("idx", 32'(spr_idx), 32'h3FF);
        check("h16", 32'(spr_h16), 32'd1);
        check("hflip", 32'(spr_hflip), 32'd0);
        check("vflip", 32'(spr_vflip), 32'd1);
        check("palette", 32'(spr_palette), 32'd3);
        check("priority", 32'(spr_priority), 32'd1);

        run_commit(0, bc, dc);
        check("nopend_busy", bc, 0);
        check("nopend_done", dc, 0);

        // Write during copy: entry 2 already copied, 40 not yet, 11 exactly at ptr.
        wr(0, 1, 7'd2, 32'h0000_0001);
        wr(0, 1, 7'd40, 32'h0000_0001);
        wr(0, 1, 7'd11, 32'h0000_0001);
        run_commit(0, bc, dc);
        wr(0, 0, 7'd10, 32'h0000_0000);
        commit_req = 1'b1;
        tick();
        commit_req = 1'b0;
        repeat (9) tick();
        wr(0, 1, 7'd2, 32'h0000_0155);
        wr(0, 1, 7'd40, 32'h0000_0140);
        wr(0, 1, 7'd11, 32'h0000_0111);
        for (int i = 0; i < 80 && busy; i++) tick();
        check("copy_end", 32'(busy), 32'd0);
        look(6'd40);
        check("wdc_e40", 32'(spr_x), 32'h140);
        look(6'd11);
        check("wdc_e11", 32'(spr_x), 32'h111);
        look(6'd2);
        check("wdc_e2_old", 32'(spr_x), 32'h001);
        run_commit(0, bc, dc);
        check("wdc_next_busy", bc, 64);
        look(6'd2);
        check("wdc_e2_new", 32'(spr_x), 32'h155);

        // Write coincident with accepted commit, plus commit_req during COPY.
        wr(0, 0, 7'd20, 32'h0000_0001);
        commit_req = 1'b1;
        wr(0, 1, 7'd3, 32'h0000_0033);
        commit_req = 1'b0;
        bc = 0;
        dc = 0;
        for (int i = 0; i < 80; i++) begin
            if (busy) bc++;
            if (done) dc++;
            commit_req = (i == 5);
            tick();
        end
        commit_req = 1'b0;
        check("simul_busy", bc, 64);
        check("simul_done", dc, 1);
        run_commit(0, bc, dc);
        check("simul_pend_busy", bc, 64);
        run_commit(0, bc, dc);
        check("simul_clear_busy", bc, 0);

        // Reset mid-copy.
        spr_sel = 6'd5;
        wr(0, 0, 7'd7, 32'h0000_0001);
        commit_req = 1'b1;
        tick();
        commit_req = 1'b0;
        repeat (19) tick();
        check("pre_rst_busy", 32'(busy), 32'd1);
        reset_n = 1'b0;
        #1;
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        check("mid_rst_idx", 32'(spr_idx), 32'd0);
        check("mid_rst_prio", 32'(spr_priority), 32'd0);
        check("mid_rst_x", 32'(spr_x), 32'd0);
        tick();
        reset_n = 1'b1;
        tick();
        run_commit(0, bc, dc);
        check("post_rst_busy", bc, 0);
        check("post_rst_done", dc, 0);

        // 128-entry, 9-bit Y build.
        wr(1, 1, 7'd100, 32'h01A5_0007);
        check("big_rd", b_rddata, 32'h01A5_0007);
        run_commit(1, bc, dc);
        check("big_busy", bc, 128);
        check("big_done", dc, 1);
        b_spr_sel = 7'd100;
        tick();
        check("big_y", 32'(b_spr_y), 32'h1A5);
        check("big_x", 32'(b_spr_x), 32'h007);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
